// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and port index constants used by the arbiter and its round-robin picker.
package mem_arb_pkg;

  // FSM encoding, kept as plain constants so legacy tools see fixed codes.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Requester indices: port 0 is instruction fetch, port 1 is data.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // With two ports the "other" requester is simply the inverted index.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker. A lone eligible port always wins; when both
// are eligible the port that did not win last time is granted.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  // Choose a winner from the eligible set and the previous grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    grant_valid_o = |eligible_i;
    grant_idx_o   = PORT_I;
    if (eligible_i[PORT_I] && eligible_i[PORT_D]) begin
      grant_idx_o = other_port(last_grant_i);
    end else if (eligible_i[PORT_D]) begin
      grant_idx_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency memory between an instruction
// fetch port (read-only) and a data port. Each access takes an ISSUE cycle
// that drives the memory strobes and a RESP cycle that returns the ack and
// the registered memory data. A new grant can be latched in RESP, so
// back-to-back requesters see one access every two cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 30,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Port 0: instruction fetch
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_ack,
  output logic [DWIDTH-1:0] i_rdata,
  // Port 1: data
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  // Memory side
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-1:0] memaddr,
  output logic [DWIDTH-1:0] wmemdata,
  input  logic [DWIDTH-1:0] rmemdata
);

  logic [1:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;

  logic [1:0]        eligible;
  logic              grant_valid;
  logic              grant_idx;

  // Requests are eligible in IDLE, and in RESP except for the port being acked.
  always_comb begin
    eligible = 2'b00;
    if (state_q == ST_IDLE) begin
      eligible = {d_req, i_req};
    end else if (state_q == ST_RESP) begin
      eligible = {d_req & (port_q != PORT_D), i_req & (port_q != PORT_I)};
    end
  end

  mem_arb_pick u_pick (
    .eligible_i    (eligible),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Next-state logic: sequence IDLE -> ISSUE -> RESP and latch each winner.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (grant_valid) begin
          state_d      = ST_ISSUE;
          port_d       = grant_idx;
          last_grant_d = grant_idx;
          if (grant_idx == PORT_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            // Instruction fetch never writes; its write data is left untouched.
            addr_d = i_addr;
            we_d   = 1'b0;
          end
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      port_q       <= PORT_I;
      we_q         <= 1'b0;
      last_grant_q <= PORT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Strobes and acks decode straight from state, so reset clears them at once.
  assign mem_re   = (state_q == ST_ISSUE) & ~we_q;
  assign mem_we   = (state_q == ST_ISSUE) &  we_q;
  assign memaddr  = addr_q;
  assign wmemdata = wdata_q;
  assign i_ack    = (state_q == ST_RESP) & (port_q == PORT_I);
  assign d_ack    = (state_q == ST_RESP) & (port_q == PORT_D);
  assign i_rdata  = rmemdata;
  assign d_rdata  = rmemdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory with ROM-like
// default contents, directed scenario tasks and a randomized two-requester
// run scored against a shadow copy of memory and the latency rules.
module tb_mem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] memaddr;
  logic [DW-1:0] wmemdata;
  logic [DW-1:0] rmemdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .memaddr  (memaddr),
    .wmemdata (wmemdata),
    .rmemdata (rmemdata)
  );

  // Initial memory contents for locations never written.
  function automatic logic [DW-1:0] rom_init(input logic [AW-1:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  // Memory environment: registered read, write on the strobe edge.
  logic [DW-1:0] ram [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_we) ram[memaddr] = wmemdata;
    if (mem_re) rmemdata <= ram.exists(memaddr) ? ram[memaddr] : rom_init(memaddr);
  end

  // Reference view of memory contents, updated when a write is acknowledged.
  logic [DW-1:0] shadow [logic [AW-1:0]];
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : rom_init(a);
  endfunction

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic ireq_e = 1'b0;
  logic dreq_e = 1'b0;

  // Advance to #1 after the next rising edge, remembering requests at the edge.
  task automatic edge_sync();
    @(posedge clk);
    ireq_e = i_req;
    dreq_e = d_req;
    #1;
    cyc++;
  endtask

  // One clock step with the always-on protocol checks at the falling edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      total++;
      if ((i_ack && d_ack) || (mem_re && mem_we) ||
          (i_ack && !ireq_e) || (d_ack && !dreq_e) ||
          ((mem_re || mem_we) && !(ireq_e || dreq_e)) ||
          ((mem_re || mem_we) && (i_ack || d_ack))) begin
        bad++;
        $display("FAIL monitor t=%0t: i_ack=%b d_ack=%b mem_re=%b mem_we=%b req_at_edge(i,d)=%b%b",
                 $time, i_ack, d_ack, mem_re, mem_we, ireq_e, dreq_e);
      end
    end
    edge_sync();
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_sync();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({i_ack, d_ack, mem_re, mem_we} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes: got i_ack,d_ack,mem_re,mem_we=%b want 0000",
               {i_ack, d_ack, mem_re, mem_we});
    end
    total++;
    if (memaddr !== '0 || wmemdata !== '0) begin
      bad++;
      $display("FAIL reset_regs: memaddr=%h wmemdata=%h want 0 0", memaddr, wmemdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    i_req  = 1'b1;
    i_addr = 30'h10;
    tick();
    total++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || memaddr !== 30'h10 || i_ack !== 1'b0) begin
      bad++;
      $display("FAIL read_issue: mem_re=%b mem_we=%b memaddr=%h i_ack=%b want 1 0 010 0",
               mem_re, mem_we, memaddr, i_ack);
    end
    tick();
    total++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== exp_rd(30'h10)) begin
      bad++;
      $display("FAIL read_ack: i_ack=%b d_ack=%b i_rdata=%h want 1 0 %h",
               i_ack, d_ack, i_rdata, exp_rd(30'h10));
    end
    i_req = 1'b0;
    tick();
    total++;
    if (i_ack !== 1'b0 || mem_re !== 1'b0) begin
      bad++;
      $display("FAIL read_after: i_ack=%b mem_re=%b want 0 0", i_ack, mem_re);
    end
  endtask

  // One data-port access from an idle arbiter with no fetch traffic.
  task automatic run_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input string tag);
    logic [DW-1:0] exp;
    exp    = exp_rd(a);
    d_req  = 1'b1;
    d_we   = we;
    d_addr = a;
    d_wdata = wd;
    tick();
    total++;
    if (mem_we !== we || mem_re !== ~we || memaddr !== a || d_ack !== 1'b0 ||
        (we && wmemdata !== wd)) begin
      bad++;
      $display("FAIL %s_issue: mem_we=%b mem_re=%b memaddr=%h wmemdata=%h d_ack=%b want we=%b addr=%h wdata=%h ack=0",
               tag, mem_we, mem_re, memaddr, wmemdata, d_ack, we, a, wd);
    end
    tick();
    total++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        (!we && d_rdata !== exp)) begin
      bad++;
      $display("FAIL %s_ack: d_ack=%b i_ack=%b mem_we=%b mem_re=%b d_rdata=%h want 1 0 0 0 rdata=%h",
               tag, d_ack, i_ack, mem_we, mem_re, d_rdata, exp);
    end
    d_req = 1'b0;
    if (we) shadow[a] = wd;
    tick();
    total++;
    if (d_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: d_ack=%b want 0", tag, d_ack);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    run_d(1'b1, 30'h20, 32'hDEAD_BEEF, "write20");
    run_d(1'b0, 30'h20, 32'h0, "read20");
    run_d(1'b0, 30'h3FFF_FFFF, 32'h0, "read_top");
  endtask

  task automatic test_both_same_edge();
    logic [DW-1:0] wd;
    do_reset();
    wd      = $urandom;
    i_req   = 1'b1;
    i_addr  = 30'h11;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 30'h21;
    d_wdata = wd;
    tick();
    total++;
    if (mem_re !== 1'b1 || memaddr !== 30'h11) begin
      bad++;
      $display("FAIL tie_first_issue: mem_re=%b memaddr=%h want 1 011", mem_re, memaddr);
    end
    tick();
    total++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== exp_rd(30'h11)) begin
      bad++;
      $display("FAIL tie_first_ack: i_ack=%b d_ack=%b i_rdata=%h want 1 0 %h",
               i_ack, d_ack, i_rdata, exp_rd(30'h11));
    end
    i_req = 1'b0;
    tick();
    total++;
    if (mem_we !== 1'b1 || memaddr !== 30'h21 || wmemdata !== wd) begin
      bad++;
      $display("FAIL tie_second_issue: mem_we=%b memaddr=%h wmemdata=%h want 1 021 %h",
               mem_we, memaddr, wmemdata, wd);
    end
    tick();
    total++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
      bad++;
      $display("FAIL tie_second_ack: d_ack=%b i_ack=%b want 1 0", d_ack, i_ack);
    end
    d_req = 1'b0;
    shadow[30'h21] = wd;
    tick();
  endtask

  task automatic test_sustained();
    int nacks;
    do_reset();
    nacks  = 0;
    i_addr = 30'h40;
    d_addr = 30'h41;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (i_ack !== (k % 4 == 2) || d_ack !== (k % 4 == 0)) begin
        bad++;
        $display("FAIL sustained_k%0d: i_ack=%b d_ack=%b want %b %b",
                 k, i_ack, d_ack, (k % 4 == 2), (k % 4 == 0));
      end
      if (i_ack || d_ack) begin
        nacks++;
        total++;
        if ((i_ack && i_rdata !== exp_rd(30'h40)) || (d_ack && d_rdata !== exp_rd(30'h41))) begin
          bad++;
          $display("FAIL sustained_data_k%0d: i_rdata=%h d_rdata=%h want %h %h",
                   k, i_rdata, d_rdata, exp_rd(30'h40), exp_rd(30'h41));
        end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    total++;
    if (nacks != 10) begin
      bad++;
      $display("FAIL sustained_count: acks=%0d want 10", nacks);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 30'h30;
    d_wdata = 32'hCAFE_F00D;
    tick();
    total++;
    if (mem_we !== 1'b1) begin
      bad++;
      $display("FAIL abort_issue: mem_we=%b want 1", mem_we);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0 || d_ack !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: mem_we=%b d_ack=%b want 0 0", mem_we, d_ack);
    end
    @(posedge clk);
    #1;
    total++;
    if (d_ack !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL abort_held: d_ack=%b mem_we=%b want 0 0", d_ack, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_sync();
    total++;
    if (mem_we !== 1'b1 || memaddr !== 30'h30 || wmemdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL reissue_issue: mem_we=%b memaddr=%h wmemdata=%h want 1 030 cafef00d",
               mem_we, memaddr, wmemdata);
    end
    tick();
    total++;
    if (d_ack !== 1'b1) begin
      bad++;
      $display("FAIL reissue_ack: d_ack=%b want 1", d_ack);
    end
    d_req = 1'b0;
    shadow[30'h30] = 32'hCAFE_F00D;
    tick();
    run_d(1'b0, 30'h30, 32'h0, "read30");
  endtask

  // Random traffic on both ports; each request must complete in 2..4 cycles
  // with data matching the shadow memory.
  task automatic test_random();
    logic i_pend, d_pend;
    int   i_t0, d_t0, lat;
    do_reset();
    i_pend = 1'b0;
    d_pend = 1'b0;
    i_t0   = 0;
    d_t0   = 0;
    for (int n = 0; n < 410; n++) begin
      tick();
      if (i_pend) begin
        lat = cyc - i_t0;
        if (i_ack) begin
          total++;
          if (lat < 2 || lat > 4 || i_rdata !== exp_rd(i_addr)) begin
            bad++;
            $display("FAIL rand_i addr=%h: latency=%0d rdata=%h want 2..4 %h",
                     i_addr, lat, i_rdata, exp_rd(i_addr));
          end
          i_req  = 1'b0;
          i_pend = 1'b0;
        end else if (lat > 4) begin
          total++;
          bad++;
          $display("FAIL rand_i_timeout addr=%h: waited %0d cycles want ack by 4", i_addr, lat);
          i_req  = 1'b0;
          i_pend = 1'b0;
        end
      end else if (n < 400 && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = AW'($urandom_range(0, 7));
        i_pend = 1'b1;
        i_t0   = cyc;
      end
      if (d_pend) begin
        lat = cyc - d_t0;
        if (d_ack) begin
          total++;
          if (lat < 2 || lat > 4 || (!d_we && d_rdata !== exp_rd(d_addr))) begin
            bad++;
            $display("FAIL rand_d addr=%h we=%b: latency=%0d rdata=%h want 2..4 %h",
                     d_addr, d_we, lat, d_rdata, exp_rd(d_addr));
          end
          if (d_we) shadow[d_addr] = d_wdata;
          d_req  = 1'b0;
          d_pend = 1'b0;
        end else if (lat > 4) begin
          total++;
          bad++;
          $display("FAIL rand_d_timeout addr=%h: waited %0d cycles want ack by 4", d_addr, lat);
          d_req  = 1'b0;
          d_pend = 1'b0;
        end
      end else if (n < 400 && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 7));
        d_wdata = $urandom;
        d_pend  = 1'b1;
        d_t0    = cyc;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_both_same_edge();
    test_sustained();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
